// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU, radix-2 restoring, MSB first.
// Ports: clk, rst (async high), start/divop/dividend/divisor in; busy, done, divout out.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      divop,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] divout
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_e;

  localparam logic [XLEN-1:0]  SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] divout_q, divout_d;

  logic            accept;
  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   shl;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;

  always_comb begin
    accept = start && (state_q != CALC);
    sgn    = ~divop[0];
    a_neg  = sgn & dividend[XLEN-1];
    b_neg  = sgn & divisor[XLEN-1];
    a_mag  = a_neg ? -dividend : dividend;
    b_mag  = b_neg ? -divisor : divisor;
    // Shifted partial remainder needs XLEN+1 bits; the borrow of the
    // wide subtract is the compare result. Stored remainder < divisor.
    shl    = {rem_q, dvd_q[XLEN-1]};
    diff   = shl - {1'b0, dvs_q};
    ge     = ~diff[XLEN];
    rem_nx = ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
    // Quotient bits shift into the dividend register as it empties.
    quo_nx = {dvd_q[XLEN-2:0], ge};
    q_fin  = negq_q ? -quo_nx : quo_nx;
    r_fin  = negr_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    divout_d = divout_q;
    unique case (state_q)
      CALC: begin
        rem_d = rem_nx;
        dvd_d = quo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d  = FIN;
          divout_d = op_q[1] ? r_fin : q_fin;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          op_d = divop;
          if (divisor == '0) begin
            state_d  = FIN;
            divout_d = divop[1] ? dividend : '1;
          end else if (sgn && dividend == SMIN && divisor == '1) begin
            state_d  = FIN;
            divout_d = divop[1] ? '0 : SMIN;
          end else begin
            state_d = CALC;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      divout_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      divout_q <= divout_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == FIN);
  assign divout = divout_q;

endmodule
